// File: rtl/axil_arbiter_rd.sv
// rtl/axil_arbiter_rd.sv - round-robin AXI-Lite read-channel arbiter
module axil_arbiter_rd #(
    parameter int NUMBER_MASTER = 2,
    localparam int IDX_W = (NUMBER_MASTER > 2) ? $clog2(NUMBER_MASTER) : 1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUMBER_MASTER-1:0] m_axil_arvalid,
    input  logic                     ar_ready,
    input  logic                     r_valid,
    input  logic                     r_ready,
    output logic [NUMBER_MASTER-1:0] grant,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     grant_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [NUMBER_MASTER-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]         grant_idx_q, grant_idx_d;
    logic                     grant_valid_q, grant_valid_d;

    logic                     found;
    logic [IDX_W-1:0]         sel_idx;
    logic                     ar_hs;
    logic                     r_hs;
    logic [IDX_W-1:0]         next_ptr;

    // First requester at or above rr_ptr, wrapping past the top master.
    always_comb begin
        int cand;
        found   = 1'b0;
        sel_idx = '0;
        cand    = 0;
        for (int i = 0; i < NUMBER_MASTER; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUMBER_MASTER;
            if (!found && m_axil_arvalid[cand]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(cand);
            end
        end
    end

    assign ar_hs    = m_axil_arvalid[grant_idx_q] && ar_ready;
    assign r_hs     = r_valid && r_ready;
    assign next_ptr = (int'(grant_idx_q) == NUMBER_MASTER - 1) ? '0 : grant_idx_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d       = NUMBER_MASTER'(1) << sel_idx;
                    grant_idx_d   = sel_idx;
                    grant_valid_d = 1'b1;
                    state_d       = ADDR;
                end
            end
            ADDR: begin
                if (ar_hs && r_hs) begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = next_ptr;
                    state_d       = IDLE;
                end else if (ar_hs) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = next_ptr;
                    state_d       = IDLE;
                end
            end
            default: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                state_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;

endmodule

// File: doc/axil_arbiter_rd.md
# axil_arbiter_rd

Read-channel arbiter for the AXI-Lite interconnect. It shares the single downstream read path (AR, R) between NUMBER_MASTER upstream masters using round-robin arbitration. The grant is held for one complete read transaction, from AR request through R handshake. The registered one-hot grant drives the AR/R muxes and the read address decoder that sit between the masters and the slave ports.

## Interface
- NUMBER_MASTER, default 2: number of upstream masters; legal range 2..16.
- IDX_W, default max(1, $clog2(NUMBER_MASTER)): width of grant_idx; derived, never overridden.
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset; synchronous, active-low.
- m_axil_arvalid  in  NUMBER_MASTER  per-master ARVALID request vector.
- ar_ready  in  1  ARREADY of the downstream path, already muxed by the current grant.
- r_valid  in  1  RVALID returned on the downstream path.
- r_ready  in  1  RREADY of the granted master, already muxed by the current grant.
- grant  out  NUMBER_MASTER  one-hot grant; all zero when no master is granted.
- grant_idx  out  IDX_W  binary index of the granted master; holds its last value when grant_valid=0.
- grant_valid  out  1  high while any master holds the grant (equals OR of grant).

## Operation
- The state machine has three states: IDLE, ADDR and DATA.
- The rotating priority pointer rr_ptr is IDX_W bits wide and resets to 0.
- IDLE, when any m_axil_arvalid bit is set:
  - Select the first set bit, searching upward from rr_ptr and wrapping from NUMBER_MASTER-1 to 0.
  - Register grant, grant_idx and grant_valid=1, then go to ADDR.
- IDLE, when no m_axil_arvalid bit is set: stay in IDLE with grant=0.
- ADDR: the AR handshake is m_axil_arvalid[grant_idx] && ar_ready.
  - Handshake and r_valid && r_ready in the same cycle: go to IDLE and release.
  - Handshake only: go to DATA.
  - No handshake: stay in ADDR and hold the grant.
- DATA: on r_valid && r_ready, go to IDLE.
  - Clear grant and grant_valid.
  - Set rr_ptr to (grant_idx+1) mod NUMBER_MASTER.
- Release always takes the path through IDLE; a grant never passes directly from one master to another.
- rr_ptr changes only on release. Requests that appear or vanish while a grant is held do not change the pointer or the grant.
- A granted master that drops arvalid while in ADDR is a protocol violation. The grant is held anyway and the block waits for arvalid && ar_ready.
- r_valid seen in ADDR before any AR handshake is ignored, unless it coincides with the handshake as described above.
- Wrap-around: after master NUMBER_MASTER-1 is released, rr_ptr wraps to 0.
- The block never hangs on its own: it stays in ADDR or DATA indefinitely only if the downstream path never handshakes.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0;
  - grant 0, grant_idx 0, grant_valid 0.
- Reset that arrives mid-transaction clears everything on the next edge, regardless of any handshake in progress.
- Grant latency: arvalid sampled in IDLE at edge N gives grant valid after edge N. This is one cycle of arbitration latency.
- Release: an R handshake at edge M gives grant=0 after edge M.
- After release, IDLE lasts at least one cycle before the next grant.
- Minimum transaction spacing is 3 cycles (IDLE, ADDR and DATA cycles), or 2 when AR and R complete in the same cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Single request:
  - Stimulus: NUMBER_MASTER=4, m_axil_arvalid=4'b0100, ar_ready one cycle later, R handshake two cycles after that.
  - Required: grant=0100 and grant_idx=2 one cycle after the request; grant held until the cycle after the R handshake; rr_ptr=3.
- Simultaneous requests:
  - Stimulus: m_axil_arvalid=4'b1111 held, each transaction completed.
  - Required: grant order 0,1,2,3,0; each grant preceded by one IDLE cycle with grant=0.
- Wrap-around:
  - Stimulus: rr_ptr=3, requests 4'b0011.
  - Required: master 0 granted, then master 1.
- Grant stability:
  - Stimulus: master 1 granted and waiting in DATA for 20 cycles while m_axil_arvalid changes randomly.
  - Required: grant stays 0010 throughout.
- Same-cycle completion:
  - Stimulus: AR and R handshake in the same ADDR cycle.
  - Required: next state IDLE; grant=0 after that edge.
- Reset mid-operation:
  - Stimulus: aresetn=0 for 1 cycle while in DATA with grant_idx=2.
  - Required: grant=0, grant_valid=0, grant_idx=0; the next request from 4'b1100 grants master 2.
